// File: rtl/mem_test_seq_pkg.sv
// Shared types and helpers for the memory-test sequencer.
// The perf counters are built only when MEM_TEST_SEQ_PERF_CNT_EN is defined.
package mem_test_seq_pkg;

  localparam int MTS_ADDR_W = 64;
  localparam int MTS_CNT_W  = 32;

  typedef enum logic [2:0] {
    MTS_IDLE,
    MTS_LOAD,
    MTS_ISSUE,
    MTS_WAIT,
    MTS_NEXT,
    MTS_DONE
  } mts_state_e;

  // Region geometry latched at LOAD. Base and iteration count are kept
  // separately because their widths are parameters of the top.
  typedef struct packed {
    logic [31:0] region_bytes;
    logic [31:0] stride;
    logic [31:0] write_delta;
  } mts_cfg_t;

  // (a + b) mod region. Both operands are already below region, so a
  // single conditional subtract suffices.
  function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] region);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, region}) s = s - {1'b0, region};
    return s[31:0];
  endfunction

endpackage

// File: rtl/mem_test_sequencer_if.sv
// Start/done/offset handshake between the sequencer and one AXI test engine.
interface mem_test_sequencer_if #(
  parameter int C_ADDR_WIDTH = 64
) ();
  logic                    eng_start;
  logic                    eng_done;
  logic [C_ADDR_WIDTH-1:0] eng_rd_offset;
  logic [C_ADDR_WIDTH-1:0] eng_wr_offset;

  modport master (output eng_start, eng_rd_offset, eng_wr_offset, input eng_done);
  modport slave  (input eng_start, eng_rd_offset, eng_wr_offset, output eng_done);
endinterface

// File: rtl/mem_test_seq_perf.sv
// Saturating run-length and worst-iteration latency counters for the sequencer.
// Instantiated only when MEM_TEST_SEQ_PERF_CNT_EN is defined.
module mem_test_seq_perf #(
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                   ap_clk,
  input  logic                   areset,
  input  logic                   clr,
  input  logic                   run_active,
  input  logic                   iter_start,
  input  logic                   iter_wait,
  input  logic                   iter_end,
  output logic [63:0]            total_cycles,
  output logic [C_CNT_WIDTH-1:0] max_iter_cycles
);

  logic [C_CNT_WIDTH-1:0] iter_cycles;

  function automatic logic [63:0] sat_inc_run(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc_iter(input logic [C_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + C_CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      total_cycles    <= '0;
      max_iter_cycles <= '0;
    end else if (clr) begin
      total_cycles    <= '0;
      max_iter_cycles <= '0;
    end else begin
      if (run_active) total_cycles <= sat_inc_run(total_cycles);
      if (iter_end && (iter_cycles > max_iter_cycles)) max_iter_cycles <= iter_cycles;
    end
  end

  // ISSUE counts as the first cycle; every WAIT cycle, including the done cycle, adds one.
  always_ff @(posedge ap_clk) begin
    if (iter_start)     iter_cycles <= C_CNT_WIDTH'(1);
    else if (iter_wait) iter_cycles <= sat_inc_iter(iter_cycles);
  end

endmodule

// File: rtl/mem_test_sequencer.sv
// Drives one AXI test engine through a series of iterations whose offsets walk a
// wrapping region. Optional perf counters: define MEM_TEST_SEQ_PERF_CNT_EN.
module mem_test_sequencer
  import mem_test_seq_pkg::*;
#(
  parameter int C_ADDR_WIDTH = MTS_ADDR_W,
  parameter int C_CNT_WIDTH  = MTS_CNT_W
) (
  input  logic                    ap_clk,
  input  logic                    areset,
  input  logic                    ap_start,
  output logic                    ap_idle,
  output logic                    ap_done,
  input  logic                    abort,
  input  logic [C_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [31:0]             cfg_region_bytes,
  input  logic [31:0]             cfg_stride,
  input  logic [31:0]             cfg_write_delta,
  input  logic [C_CNT_WIDTH-1:0]  cfg_num_iters,
  mem_test_sequencer_if.master    eng,
  output logic [C_CNT_WIDTH-1:0]  iter_count,
  output logic                    cfg_err
`ifdef MEM_TEST_SEQ_PERF_CNT_EN
  ,
  output logic [63:0]             total_cycles,
  output logic [C_CNT_WIDTH-1:0]  max_iter_cycles
`endif
);

  mts_state_e              state, state_nxt;
  mts_cfg_t                cfg_q;
  logic [C_ADDR_WIDTH-1:0] base_q;
  logic [C_CNT_WIDTH-1:0]  num_iters_q;
  logic [31:0]             cursor;
  logic [31:0]             cur_adv;
  logic [31:0]             wr_rel_adv;
  logic [C_CNT_WIDTH-1:0]  iter_inc;
  logic                    abort_q;
  logic                    start_acc;
  logic                    cfg_bad;

  assign start_acc  = (state == MTS_IDLE) && ap_start;
  assign cfg_bad    = (cfg_region_bytes == 32'd0) || (cfg_stride >= cfg_region_bytes) ||
                      (cfg_write_delta >= cfg_region_bytes);
  assign iter_inc   = iter_count + C_CNT_WIDTH'(1);
  assign cur_adv    = wrap_add(cursor, cfg_q.stride, cfg_q.region_bytes);
  assign wr_rel_adv = wrap_add(cur_adv, cfg_q.write_delta, cfg_q.region_bytes);

  always_ff @(posedge ap_clk) begin
    if (areset) state <= MTS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      MTS_IDLE:  if (ap_start) state_nxt = MTS_LOAD;
      MTS_LOAD:  state_nxt = (cfg_bad || (cfg_num_iters == '0)) ? MTS_DONE : MTS_ISSUE;
      MTS_ISSUE: state_nxt = MTS_WAIT;
      MTS_WAIT:  if (eng.eng_done) state_nxt = MTS_NEXT;
      MTS_NEXT:  state_nxt = ((iter_inc == num_iters_q) || abort_q) ? MTS_DONE : MTS_ISSUE;
      MTS_DONE:  state_nxt = MTS_IDLE;
      default:   state_nxt = MTS_IDLE;
    endcase
  end

  always_comb begin
    ap_idle       = (state == MTS_IDLE);
    ap_done       = (state == MTS_DONE);
    eng.eng_start = (state == MTS_ISSUE);
  end

  // Results stay readable in IDLE and are cleared only when a new run is accepted.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      iter_count        <= '0;
      cfg_err           <= 1'b0;
      abort_q           <= 1'b0;
      eng.eng_rd_offset <= '0;
      eng.eng_wr_offset <= '0;
    end else begin
      unique case (state)
        MTS_IDLE: if (start_acc) begin
          iter_count <= '0;
          cfg_err    <= 1'b0;
        end
        MTS_LOAD: begin
          cfg_err           <= cfg_bad;
          eng.eng_rd_offset <= cfg_base_addr;
          eng.eng_wr_offset <= cfg_base_addr +
                               C_ADDR_WIDTH'(wrap_add(32'd0, cfg_write_delta, cfg_region_bytes));
        end
        MTS_ISSUE, MTS_WAIT: if (abort) abort_q <= 1'b1;
        MTS_NEXT: begin
          iter_count        <= iter_inc;
          eng.eng_rd_offset <= base_q + C_ADDR_WIDTH'(cur_adv);
          eng.eng_wr_offset <= base_q + C_ADDR_WIDTH'(wr_rel_adv);
        end
        MTS_DONE: abort_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (start_acc) cursor <= 32'd0;
    else if (state == MTS_NEXT) cursor <= cur_adv;
    if (state == MTS_LOAD) begin
      cfg_q.region_bytes <= cfg_region_bytes;
      cfg_q.stride       <= cfg_stride;
      cfg_q.write_delta  <= cfg_write_delta;
      base_q             <= cfg_base_addr;
      num_iters_q        <= cfg_num_iters;
    end
  end

`ifdef MEM_TEST_SEQ_PERF_CNT_EN
  mem_test_seq_perf #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_perf (
    .ap_clk          (ap_clk),
    .areset          (areset),
    .clr             (start_acc),
    .run_active      (state != MTS_IDLE),
    .iter_start      (state == MTS_ISSUE),
    .iter_wait       (state == MTS_WAIT),
    .iter_end        (state == MTS_NEXT),
    .total_cycles    (total_cycles),
    .max_iter_cycles (max_iter_cycles)
  );
`endif

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Randomized self-checking bench for mem_test_sequencer against a run-level
// reference model (offsets from k*stride mod region, timing from engine latencies).
module tb_mem_test_sequencer;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic        abort;
  logic [63:0] cfg_base_addr;
  logic [31:0] cfg_region_bytes;
  logic [31:0] cfg_stride;
  logic [31:0] cfg_write_delta;
  logic [31:0] cfg_num_iters;
  logic [31:0] iter_count;
  logic        cfg_err;
`ifdef MEM_TEST_SEQ_PERF_CNT_EN
  logic [63:0] total_cycles;
  logic [31:0] max_iter_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_test_sequencer_if #(.C_ADDR_WIDTH(64)) eng_if ();

  mem_test_sequencer #(.C_ADDR_WIDTH(64), .C_CNT_WIDTH(32)) dut (
    .ap_clk           (ap_clk),
    .areset           (areset),
    .ap_start         (ap_start),
    .ap_idle          (ap_idle),
    .ap_done          (ap_done),
    .abort            (abort),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_region_bytes (cfg_region_bytes),
    .cfg_stride       (cfg_stride),
    .cfg_write_delta  (cfg_write_delta),
    .cfg_num_iters    (cfg_num_iters),
    .eng              (eng_if.master),
    .iter_count       (iter_count),
    .cfg_err          (cfg_err)
`ifdef MEM_TEST_SEQ_PERF_CNT_EN
    ,
    .total_cycles     (total_cycles),
    .max_iter_cycles  (max_iter_cycles)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Cycle 0 is the cycle in which ap_start is presented.
  task automatic run_seq(input logic [63:0] base, input logic [31:0] region,
                         input logic [31:0] stride, input logic [31:0] delta,
                         input int iters, input int fixed_lat, input int abort_iter,
                         input bit poke);
    int          starts[$];
    int          lats[$];
    logic [63:0] rds[$];
    logic [63:0] wrs[$];
    int          done_cyc, n_done, done_due, abort_due, lat, n_exp, exp_c, max_l, n_cmp;
    bit          legal;
    logic [63:0] cur;

    legal     = (region != 0) && (stride < region) && (delta < region);
    done_cyc  = -1;
    n_done    = 0;
    done_due  = -1;
    abort_due = -1;

    cfg_base_addr    = base;
    cfg_region_bytes = region;
    cfg_stride       = stride;
    cfg_write_delta  = delta;
    cfg_num_iters    = iters;
    ap_start         = 1'b1;

    for (int c = 1; c <= 600 && done_cyc < 0; c++) begin
      tick();
      ap_start       = 1'b0;
      abort          = 1'b0;
      eng_if.eng_done = 1'b0;
      if (c == 1) check_eq("idle_fall", ap_idle, 1'b0);
      if (c == 2) begin
        cfg_base_addr    = {$urandom, $urandom};
        cfg_region_bytes = $urandom;
        cfg_stride       = $urandom;
        cfg_write_delta  = $urandom;
        cfg_num_iters    = $urandom;
      end
      if (poke && legal && iters > 0 && c == 3) ap_start = 1'b1;
      if (eng_if.eng_start) begin
        lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 12);
        starts.push_back(c);
        lats.push_back(lat);
        rds.push_back(eng_if.eng_rd_offset);
        wrs.push_back(eng_if.eng_wr_offset);
        done_due = c + lat;
        if (starts.size() == abort_iter) abort_due = c + $urandom_range(0, lat);
      end
      if (c == done_due)  eng_if.eng_done = 1'b1;
      if (c == abort_due) abort = 1'b1;
      if (ap_done) begin
        done_cyc = c;
        n_done++;
      end
    end
    check_eq("done_seen", done_cyc >= 0, 1'b1);

    tick();
    eng_if.eng_done = 1'b0;
    abort           = 1'b0;
    check_eq("idle_rise", ap_idle, 1'b1);
    check_eq("done_pulse", ap_done, 1'b0);

    if (!legal || iters == 0) n_exp = 0;
    else if (abort_iter >= 1 && abort_iter < iters) n_exp = abort_iter;
    else n_exp = iters;

    check_eq("n_starts", starts.size(), n_exp);
    n_cmp = (starts.size() < n_exp) ? starts.size() : n_exp;
    exp_c = 2;
    max_l = 0;
    for (int k = 0; k < n_cmp; k++) begin
      cur = (64'(k) * 64'(stride)) % 64'(region);
      check_eq("start_cyc", starts[k], exp_c);
      check_eq("rd_offset", rds[k], base + cur);
      check_eq("wr_offset", wrs[k], base + ((cur + 64'(delta)) % 64'(region)));
      exp_c = exp_c + lats[k] + 2;
      if (lats[k] + 1 > max_l) max_l = lats[k] + 1;
    end
    check_eq("done_cyc", done_cyc, exp_c);
    check_eq("iter_count", iter_count, n_exp);
    check_eq("cfg_err", cfg_err, !legal);
`ifdef MEM_TEST_SEQ_PERF_CNT_EN
    check_eq("total_cycles", total_cycles, exp_c);
    check_eq("max_iter_cycles", max_iter_cycles, max_l);
`endif

    if (done_cyc < 0) begin
      areset = 1'b1;
      tick();
      areset = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] region, stride, delta;
    int          iters;

    areset          = 1'b1;
    ap_start        = 1'b0;
    abort           = 1'b0;
    eng_if.eng_done = 1'b0;
    cfg_base_addr    = '0;
    cfg_region_bytes = '0;
    cfg_stride       = '0;
    cfg_write_delta  = '0;
    cfg_num_iters    = '0;
    repeat (3) tick();
    check_eq("rst_idle", ap_idle, 1'b1);
    check_eq("rst_done", ap_done, 1'b0);
    check_eq("rst_eng_start", eng_if.eng_start, 1'b0);
    check_eq("rst_iter_count", iter_count, 0);
    check_eq("rst_cfg_err", cfg_err, 1'b0);
    check_eq("rst_rd_offset", eng_if.eng_rd_offset, 0);
    check_eq("rst_wr_offset", eng_if.eng_wr_offset, 0);
`ifdef MEM_TEST_SEQ_PERF_CNT_EN
    check_eq("rst_total_cycles", total_cycles, 0);
    check_eq("rst_max_iter", max_iter_cycles, 0);
`endif
    areset = 1'b0;
    tick();

    // Stray engine completion while idle.
    eng_if.eng_done = 1'b1;
    tick();
    eng_if.eng_done = 1'b0;
    check_eq("spurious_idle", ap_idle, 1'b1);
    check_eq("spurious_start", eng_if.eng_start, 1'b0);
    tick();
    check_eq("spurious_idle2", ap_idle, 1'b1);

    run_seq(64'h1000, 32'h400, 32'h100, 32'h200, 6, 0, 0, 1'b0);
    run_seq(64'h1000, 32'h400, 32'h100, 32'h200, 3, 10, 0, 1'b0);
    run_seq(64'h1000, 32'h400, 32'h400, 32'h200, 3, 0, 0, 1'b0);
    run_seq(64'h1000, 32'h400, 32'h100, 32'h200, 0, 0, 0, 1'b0);
    run_seq(64'h2000, 32'h300, 32'h40, 32'h2c0, 5, 0, 2, 1'b0);

    // Reset while the engine is busy, then a fresh run must start from cursor 0.
    cfg_base_addr    = 64'h8000;
    cfg_region_bytes = 32'h200;
    cfg_stride       = 32'h80;
    cfg_write_delta  = 32'h100;
    cfg_num_iters    = 4;
    ap_start         = 1'b1;
    tick();
    ap_start = 1'b0;
    repeat (4) tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check_eq("midrst_idle", ap_idle, 1'b1);
    check_eq("midrst_eng_start", eng_if.eng_start, 1'b0);
    check_eq("midrst_rd_offset", eng_if.eng_rd_offset, 0);
    check_eq("midrst_wr_offset", eng_if.eng_wr_offset, 0);
    tick();
    run_seq(64'h8000, 32'h200, 32'h80, 32'h100, 4, 0, 0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      region = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
      stride = 32'($urandom_range(0, int'(region) + 1));
      delta  = 32'($urandom_range(0, int'(region) + 1));
      iters  = $urandom_range(0, 6);
      run_seq({32'd0, $urandom}, region, stride, delta, iters, 0,
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, iters + 1) : 0,
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_test_sequencer.md
# mem_test_sequencer

Control-plane sequencer that drives one AXI read/write test engine (one `m_axi` master datapath) through a programmed series of test iterations. It sits between the kernel control block (`ap_start`/`ap_done`) and the engine's `ap_start`/`ap_done`/offset inputs. Each iteration presents a new read/write offset pair that walks a bounded memory region with a programmable stride and wraps at the region end. Optional counters report per-run and worst-case iteration latency.

## Interface
Parameters:
- `C_ADDR_WIDTH`, default 64: width of the base and offset outputs.
- `C_CNT_WIDTH`, default 32: width of the iteration and latency counters.

Ports:
- `ap_clk`, in, 1: clock.
- `areset`, in, 1: reset, synchronous, active-high.
- `ap_start`, in, 1: single-cycle start pulse; ignored unless idle.
- `ap_idle`, out, 1: high in IDLE.
- `ap_done`, out, 1: one-cycle pulse at run end.
- `abort`, in, 1: request early stop.
- `cfg_base_addr`, in, `C_ADDR_WIDTH`: region base.
- `cfg_region_bytes`, in, 32: region size in bytes.
- `cfg_stride`, in, 32: read-offset advance per iteration.
- `cfg_write_delta`, in, 32: write offset minus read offset, taken modulo the region.
- `cfg_num_iters`, in, `C_CNT_WIDTH`: number of iterations to run.
- `eng_start`, out, 1: one-cycle start pulse to the engine.
- `eng_done`, in, 1: engine completion pulse.
- `eng_rd_offset`, out, `C_ADDR_WIDTH`: engine read offset.
- `eng_wr_offset`, out, `C_ADDR_WIDTH`: engine write offset.
- `iter_count`, out, `C_CNT_WIDTH`: iterations completed this run.
- `cfg_err`, out, 1: the last run was rejected due to illegal configuration.
- `total_cycles`, out, 64: run length in cycles (present only with the perf macro).
- `max_iter_cycles`, out, `C_CNT_WIDTH`: worst iteration latency (present only with the perf macro).

## Operation
States are IDLE, LOAD, ISSUE, WAIT, NEXT and DONE.

- **IDLE**
  - On `ap_start`, go to LOAD.
  - Clear `iter_count` and the cursor.
  - Clear `cfg_err` and the perf counters.
- **LOAD**
  - Latch all `cfg_*` inputs; later changes to them are ignored until the next run.
  - If any of these hold, set `cfg_err` and go to DONE without issuing `eng_start`:
    - `cfg_region_bytes == 0`
    - `cfg_stride >= cfg_region_bytes`
    - `cfg_write_delta >= cfg_region_bytes`
  - If `cfg_num_iters == 0`, go to DONE with `cfg_err = 0`.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `eng_start` is high for exactly this cycle. Go to WAIT.
- **WAIT**
  - Hold until `eng_done`.
  - `abort` seen in WAIT or ISSUE is latched. The in-flight iteration always completes, because AXI traffic is never abandoned.
- **NEXT**
  - Increment `iter_count`.
  - Advance the cursor: `c' = c + stride`; if `c' >= region`, then `c' = c' - region`. Compute this in 33 bits; there is no overflow.
  - Go to DONE if `iter_count == num_iters` or abort is latched; otherwise go to ISSUE.
- **DONE**
  - `ap_done` is high for one cycle. Clear the abort latch. Go to IDLE.

Offsets:
- `eng_rd_offset = base + cursor`.
- `eng_wr_offset = base + ((cursor + write_delta) mod region)`. A single conditional subtract is sufficient given the LOAD checks.
- Both offsets are registered and stable from ISSUE until the following NEXT.

Other rules:
- `eng_done` outside WAIT is ignored.
- A simultaneous `ap_start` and `abort` while in IDLE starts a run. That abort is dropped.

## Timing
Reset values:
- `ap_idle = 1`.
- All other outputs are 0, and the state is IDLE.
- A reset mid-run returns the block to IDLE within one cycle. Quiescing the engine is the responsibility of the engine's own reset.

Latencies:
- `ap_start` at cycle 0 → `eng_start` at cycle 2.
- `eng_done` at cycle t → next `eng_start` at t+2, or `ap_done` at t+2 after the final iteration.
- Rejected or zero-iteration run: `ap_done` at cycle 2.
- `ap_idle` falls at cycle 1 and rises the cycle after `ap_done`.

## Configuration
Macro: `MEM_TEST_SEQ_PERF_CNT_EN`.

When the macro is defined:
- `total_cycles` counts every cycle from LOAD through DONE inclusive.
- The per-iteration counter counts from ISSUE up to and including the `eg_done` cycle. NEXT updates `max_iter_cycles` with the maximum.
- All counters saturate at all-ones.

When the macro is undefined:
- The counter logic and both ports are removed.
- The sequencing behaviour is cycle-identical.

## Structure
Package `mem_test_seq_pkg` contains:
- The state enum `mts_state_e`.
- Default width constants.
- The latched-configuration struct `mts_cfg_t`.

Sub-module `mem_test_seq_perf` holds the saturating counters. It is instantiated only under the macro.

## Test plan
- base=0x1000, region=0x400, stride=0x100, delta=0x200, iters=6 → read offsets 0x1000, 0x1100, 0x1200, 0x1300, 0x1000, 0x1100; write offsets 0x1200, 0x1300, 0x1000, 0x1100, 0x1200, 0x1300; `iter_count` = 6; `ap_done` once.
- Engine model with fixed latency of 10 cycles, iters=3 → `eng_start` at cycles 2, 14, 26; `ap_done` at cycle 38; `total_cycles` = 38; `max_iter_cycles` = 11.
- stride=0x400 with region=0x400 → `cfg_err` = 1; no `eng_start`; `ap_done` at cycle 2. The same timing applies with iters=0, but with `cfg_err` = 0.
- `abort` pulsed mid-WAIT of iteration 2 of 5 → that iteration completes; `ap_done` 2 cycles after its `eng_done`; `iter_count` = 2.
- `areset` asserted in WAIT, then a new `ap_start` → clean run from cursor 0; spurious `eng_done` in IDLE has no effect; `ap_start` while busy is ignored.
